// File: rtl/system_wrapper.sv
// system_wrapper: two independent registered AND channels (scalar and W1-bit vector)
module system_wrapper #(
  parameter int W1 = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a,
  input  logic          b,
  input  logic [W1-1:0] a_1,
  input  logic [W1-1:0] b_1,
  output logic          y,
  output logic [W1-1:0] y_1
);
  logic          y_d, y_q;
  logic [W1-1:0] y_1_d, y_1_q;
  // next values: plain bitwise AND, no cross-bit or cross-channel terms
  always_comb begin
    y_d = a & b;
    y_1_d = a_1 & b_1;
  end
  // output registers, synchronous reset wins over data
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= 1'b0;
      y_1_q <= '0;
    end else begin
      y_q <= y_d;
      y_1_q <= y_1_d;
    end
  end
  assign y = y_q;
  assign y_1 = y_1_q;
endmodule

// File: tb/tb_system_wrapper.sv
// tb_system_wrapper: directed vectors with a scoreboard queue and a decoupled monitor
module tb_system_wrapper;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0, b = 1'b0;
  logic [2:0] a_1 = '0, b_1 = '0;
  logic       y;
  logic [2:0] y_1;
  int         tests = 0;
  int         fails = 0;
  typedef struct {
    string      name;
    logic       ey;
    logic [2:0] ey1;
  } exp_t;
  exp_t sb[$];
  system_wrapper #(.W1(3)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .a_1(a_1), .b_1(b_1), .y(y), .y_1(y_1)
  );
  always #5 clk = ~clk;
  // drive one vector in the low phase; its result is due after the next rising edge
  task automatic step(input logic r, input logic ia, input logic ib, input logic [2:0] ia1,
                      input logic [2:0] ib1, input logic ey, input logic [2:0] ey1, input string name);
    exp_t e;
    @(negedge clk);
    reset = r; a = ia; b = ib; a_1 = ia1; b_1 = ib1;
    e.name = name; e.ey = ey; e.ey1 = ey1;
    sb.push_back(e);
  endtask
  // monitor: every edge with an outstanding expectation produces one checked result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        if (y !== e.ey || y_1 !== e.ey1) begin
          fails++;
          $display("FAIL %s: got y=%b y_1=%0d, expected y=%b y_1=%0d", e.name, y, y_1, e.ey, e.ey1);
        end
      end
    end
  end
  initial begin
    step(1, 1, 1, 7, 7, 0, 0, "reset_edge1");
    step(1, 1, 1, 7, 7, 0, 0, "reset_edge2");
    step(0, 1, 1, 7, 7, 1, 7, "reset_release");
    step(0, 0, 0, 7, 7, 0, 7, "sc_00");
    step(0, 1, 0, 7, 7, 0, 7, "sc_10");
    step(0, 1, 1, 7, 7, 1, 7, "sc_11");
    step(0, 0, 1, 7, 7, 0, 7, "sc_01");
    step(0, 1, 0, 7, 7, 0, 7, "sc_10b");
    step(0, 1, 1, 7, 7, 1, 7, "sc_11b");
    step(0, 1, 0, 7, 7, 0, 7, "sc_10c");
    step(0, 1, 0, 0, 0, 0, 0, "vec_0_0");
    step(0, 1, 0, 3, 0, 0, 0, "vec_3_0");
    step(0, 1, 0, 3, 1, 0, 1, "vec_3_1");
    step(0, 1, 0, 1, 3, 0, 1, "vec_1_3");
    step(0, 1, 0, 0, 3, 0, 0, "vec_0_3");
    step(0, 1, 0, 7, 5, 0, 5, "vec_7_5");
    step(0, 1, 0, 6, 3, 0, 2, "vec_6_3");
    step(0, 1, 1, 6, 3, 1, 2, "lat_setup");
    @(posedge clk);
    #3 a = 1'b0;
    #1;
    tests++;
    if (y !== 1'b1) begin
      fails++;
      $display("FAIL lat_midcycle: got y=%b, expected y=1 until next edge", y);
    end
    step(0, 0, 1, 6, 3, 0, 2, "lat_next_edge");
    step(0, 1, 1, 7, 5, 1, 5, "rst_mid_setup");
    step(1, 1, 1, 7, 5, 0, 0, "rst_mid_pulse");
    step(0, 1, 1, 7, 5, 1, 5, "rst_mid_release");
    step(1, 0, 1, 5, 7, 0, 0, "rst_wins_change");
    step(0, 1, 1, 7, 7, 1, 7, "simul_setup");
    step(0, 0, 1, 1, 3, 0, 1, "simul_change");
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/system_wrapper.md
Name: system_wrapper

Overview:
- Top-level wrapper of a small gate-level system with two independent AND channels.
- Scalar channel: y = a AND b.
- Vector channel: y_1 = bitwise AND of a_1 and b_1, default 3 bits wide.
- Both results are registered on one clock with a synchronous active-high reset. The block is a leaf used as a board top or a test target; it has no handshake.

Parameters:
- W1, 3, width of the vector channel (a_1, b_1, y_1); legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  1  scalar operand A.
- b  input  1  scalar operand B.
- a_1  input  W1  vector operand A.
- b_1  input  W1  vector operand B.
- y  output  1  registered a AND b.
- y_1  output  W1  registered bitwise a_1 AND b_1.

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled only on the rising edge of clk, and there are no asynchronous paths.
- Reset values:
  - y = 0 and y_1 = 0 after any rising edge with reset = 1.
  - Outputs are undefined before the first clock edge. The bench must assert reset for at least one edge.
- Normal operation at each rising edge with reset = 0:
  - y <= a & b.
  - y_1[i] <= a_1[i] & b_1[i] for every i in 0..W1-1.
- Latency:
  - Exactly 1 cycle from sampled inputs to outputs.
  - Outputs hold their value between edges and are glitch-free.
  - There is no combinational path from any input to any output.
- Channel independence:
  - The scalar and vector channels share only clk and reset.
  - A change on one channel never affects the other channel's output.
- Width rules:
  - No carries, no reduction, no sign handling.
  - Each output bit depends only on the same-index input bits.
- Boundary conditions:
  - Reset wins over data in the same cycle: if inputs change in the same cycle reset is high, outputs still go to 0.
  - Deasserting reset mid-stream: the first edge with reset = 0 loads the current inputs, so the result is visible one cycle after deassertion.
  - Asserting reset mid-operation: outputs clear to 0 on that edge regardless of inputs. Previous values are not retained.
  - All-ones inputs give all-ones outputs; any zero operand bit forces the corresponding output bit to 0.
- Inputs are assumed synchronous to clk. No internal synchronizers are required.

Test Plan:
1. Reset: drive a = 1, b = 1, a_1 = 7, b_1 = 7 with reset = 1 for 2 edges -> y = 0, y_1 = 0 throughout. Deassert reset -> y = 1, y_1 = 7 one edge later.
2. Scalar truth table:
   - Apply (a, b) = (0,0), (1,0), (1,1), (0,1), (1,0), (1,1), (1,0) on successive cycles.
   - Expected y one cycle later in each case: 0, 0, 1, 0, 0, 1, 0.
   - y_1 must stay unchanged throughout.
3. Vector AND:
   - (a_1, b_1) = (0,0) -> y_1 = 0.
   - (3,0) -> 0.
   - (3,1) -> 1.
   - (1,3) -> 1.
   - (0,3) -> 0.
   - (7,5) -> 5.
   - (6,3) -> 2.
   - Each result appears after 1 edge, and y is unaffected.
4. Latency/no-comb-path: toggle a between edges while b = 1 -> y changes only at the next rising edge, never mid-cycle.
5. Reset mid-operation: with y = 1 and y_1 = 5 established, pulse reset for one edge while inputs are held -> y = 0, y_1 = 0 on that edge, then y = 1, y_1 = 5 on the following edge.
6. Simultaneous change: change all four inputs in the same cycle, from (1,1,7,7) to (0,1,1,3) -> next edge gives y = 0, y_1 = 1.
